// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the CSCv2 PC/flags sequencer.
//   seq_state_t   : sequencer state (RUN, HALT)
//   RESET_PC      : PC value loaded on reset
//   FLAG_N/Z/V/C  : bit positions inside the 4-bit NZVC vector
//   *_WIDTH_DEF   : default PC and retired-counter widths
package pc_seq_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } seq_state_t;

   localparam int unsigned PC_WIDTH_DEF  = 16;
   localparam int unsigned CNT_WIDTH_DEF = 16;

   localparam logic [15:0] RESET_PC = 16'h0000;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/pc_sequencer_nzvc_reg.sv
// nzvc_reg: 4-bit {N,Z,V,C} flags register with write enable.
//   clk      : rising-edge clock
//   reset    : synchronous, active-high; clears the flags
//   we       : load d on this edge
//   d        : incoming ALU flags {N,Z,V,C}
//   q        : registered flags
module nzvc_reg
   import pc_seq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [3:0] d,
   output logic [3:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and NZVC flags sequencer for the CSCv2 datapath.
// Holds the PC and flags feeding the bottom jump ROM, steps or jumps the PC on
// each retired instruction, halts on a jump-to-self and counts retirements.
//
// Optional feature macro: LINK_REG_EN (one-deep call/return link register).
//
// Ports:
//   clk, reset   : clock; synchronous active-high reset
//   stall        : hold all state this cycle
//   jump_taken   : current instruction branches to jump_addr
//   jump_addr    : jump target {top ROM addr, bottom ROM addr}
//   flags_we     : latch flags_in on a retiring cycle
//   flags_in     : ALU flags {N,Z,V,C}
//   call, ret    : subroutine call qualifier / return (LINK_REG_EN only)
//   pc           : current PC, pc[7:0] to bottom ROM
//   nzvc         : registered flags to bottom ROM
//   halted       : sequencer is in HALT
//   retired      : saturating retired-instruction count
//   link         : link register (0 without LINK_REG_EN)
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 jump_taken,
   input  logic [PC_WIDTH-1:0]  jump_addr,
   input  logic                 flags_we,
   input  logic [3:0]           flags_in,
   input  logic                 call,
   input  logic                 ret,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [3:0]           nzvc,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] retired,
   output logic [PC_WIDTH-1:0]  link
);

   seq_state_t state;
   logic       retire;
   logic       self_jump;

   assign retire = (state == RUN) && !stall;

`ifdef LINK_REG_EN
   // A return overrides the jump, so it can never be a halting self-jump.
   assign self_jump = jump_taken && !ret && (jump_addr == pc);
`else
   assign self_jump = jump_taken && (jump_addr == pc);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= PC_WIDTH'(RESET_PC);
         state   <= RUN;
         halted  <= 1'b0;
         retired <= '0;
      end else if (retire) begin
         if (retired != '1) begin
            retired <= retired + CNT_WIDTH'(1);
         end
         if (self_jump) begin
            state  <= HALT;
            halted <= 1'b1;
         end
`ifdef LINK_REG_EN
         if (ret) begin
            pc <= link;
         end else
`endif
         if (jump_taken) begin
            pc <= jump_addr;
         end else begin
            pc <= pc + PC_WIDTH'(1);
         end
      end
   end

`ifdef LINK_REG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         link <= '0;
      end else if (retire && call && jump_taken && !ret) begin
         link <= pc + PC_WIDTH'(1);
      end
   end
`else
   logic unused_link_inputs;
   assign unused_link_inputs = call ^ ret;
   assign link = '0;
`endif

   nzvc_reg u_nzvc_reg (
      .clk   (clk),
      .reset (reset),
      .we    (retire && flags_we),
      .d     (flags_in),
      .q     (nzvc)
   );

endmodule
